// File: rtl/rx_deframe_1to8.sv
// rx_deframe_1to8
// Receive-side deframer in the clk20m domain. Takes a 1-bit MSB-first stream,
// hunts for the sync word, parses the IDENT/LEN header, emits payload bytes
// and checks the trailing CRC16 (poly 8005, init FFFF, no reflection, xorout 0)
// computed over the payload only.
// Frame: SYNC(16) | IDENT(8) | LEN(8) | PAYLOAD(LEN bytes) | CRC(16)
//
// Build option: define SYNC_TOL1_EN to also accept a sync pattern at Hamming
// distance 1 from SYNC_WORD. Without it only an exact match is accepted.
//
// Ports:
//   i_clk20m      sole clock
//   i_rst         synchronous active-high reset
//   i_bit         serial data bit (used only when i_bit_valid=1)
//   i_bit_valid   qualifier for i_bit
//   o_ident       IDENT of the current frame, held until the next header
//   o_len         LEN of the current frame, held until the next header
//   o_data        payload byte (held between pulses)
//   o_data_valid  one-cycle pulse per payload byte
//   o_sof         with the first payload byte, or with o_crc_done when LEN=0
//   o_eof         with the last payload byte
//   o_crc_done    one-cycle pulse, CRC result valid
//   o_crc_ok      1 when the received CRC matched, valid with o_crc_done
//   o_abort       one-cycle pulse, frame dropped (gap timeout or LEN>MAX_LEN)
module rx_deframe_1to8 #(
    parameter logic [15:0] SYNC_WORD = 16'hEB90,
    parameter logic [7:0]  MAX_LEN   = 8'd240,
    parameter int unsigned GAP_MAX   = 16
) (
    input  logic       i_clk20m,
    input  logic       i_rst,
    input  logic       i_bit,
    input  logic       i_bit_valid,
    output logic [7:0] o_ident,
    output logic [7:0] o_len,
    output logic [7:0] o_data,
    output logic       o_data_valid,
    output logic       o_sof,
    output logic       o_eof,
    output logic       o_crc_done,
    output logic       o_crc_ok,
    output logic       o_abort
);

    localparam int GAP_W = $clog2(GAP_MAX + 2);
    localparam logic [GAP_W-1:0] GAP_LIMIT = GAP_W'(GAP_MAX);

    typedef enum logic [1:0] {ST_HUNT, ST_HDR, ST_PAY, ST_CRC} state_t;

    // Bytewise CRC16 update, MSB of the byte first.
    function automatic logic [15:0] crc16Byte(input logic [15:0] crcIn, input logic [7:0] dataIn);
        logic [15:0] c;
        c = crcIn;
        for (int i = 7; i >= 0; i--) begin
            if (c[15] ^ dataIn[i]) c = {c[14:0], 1'b0} ^ 16'h8005;
            else                   c = {c[14:0], 1'b0};
        end
        return c;
    endfunction

    state_t             state_q, state_d;
    logic [14:0]        hist_q, hist_d;
    logic [3:0]         bitCnt_q, bitCnt_d;
    logic [7:0]         byteCnt_q, byteCnt_d;
    logic [GAP_W-1:0]   gapCnt_q, gapCnt_d;
    logic [15:0]        crc_q, crc_d;
    logic [7:0]         ident_q, ident_d;
    logic [7:0]         len_q, len_d;
    logic [7:0]         data_q, data_d;
    logic               dataValid_q, dataValid_d;
    logic               sof_q, sof_d;
    logic               eof_q, eof_d;
    logic               crcDone_q, crcDone_d;
    logic               crcOk_q, crcOk_d;
    logic               abort_q, abort_d;
    logic               toHunt;

    // The 16-bit shift register is kept as the 15 older bits plus the bit being
    // sampled, so "window" is the register contents after this cycle's shift.
    logic [15:0] window;
    logic [15:0] syncDiff;
    logic        syncHit;

    assign window   = {hist_q, i_bit};
    assign syncDiff = window ^ SYNC_WORD;
`ifdef SYNC_TOL1_EN
    // Zero or exactly one differing bit: clearing the lowest set bit leaves nothing.
    assign syncHit  = ((syncDiff & (syncDiff - 16'd1)) == 16'd0);
`else
    assign syncHit  = (syncDiff == 16'd0);
`endif

    // Next-state logic: sync hunt, header/payload/CRC bit collection and the
    // inter-bit gap watchdog. Every exit to HUNT clears the window and counters.
    always_comb begin
        state_d     = state_q;
        hist_d      = hist_q;
        bitCnt_d    = bitCnt_q;
        byteCnt_d   = byteCnt_q;
        gapCnt_d    = gapCnt_q;
        crc_d       = crc_q;
        ident_d     = ident_q;
        len_d       = len_q;
        data_d      = data_q;
        crcOk_d     = crcOk_q;
        dataValid_d = 1'b0;
        sof_d       = 1'b0;
        eof_d       = 1'b0;
        crcDone_d   = 1'b0;
        abort_d     = 1'b0;
        toHunt      = 1'b0;

        if (state_q == ST_HUNT) begin
            if (i_bit_valid) begin
                hist_d = window[14:0];
                if (syncHit) begin
                    state_d   = ST_HDR;
                    bitCnt_d  = 4'd0;
                    byteCnt_d = 8'd0;
                    gapCnt_d  = '0;
                    crc_d     = 16'hFFFF;
                end
            end
        end else if (!i_bit_valid) begin
            if (gapCnt_q == GAP_LIMIT) begin
                abort_d = 1'b1;
                toHunt  = 1'b1;
            end else begin
                gapCnt_d = gapCnt_q + 1'b1;
            end
        end else begin
            gapCnt_d = '0;
            hist_d   = window[14:0];
            bitCnt_d = bitCnt_q + 4'd1;
            case (state_q)
                ST_HDR: begin
                    if (bitCnt_q == 4'd15) begin
                        ident_d   = window[15:8];
                        len_d     = window[7:0];
                        bitCnt_d  = 4'd0;
                        byteCnt_d = 8'd0;
                        if (window[7:0] > MAX_LEN) begin
                            abort_d = 1'b1;
                            toHunt  = 1'b1;
                        end else if (window[7:0] == 8'd0) begin
                            state_d = ST_CRC;
                        end else begin
                            state_d = ST_PAY;
                        end
                    end
                end
                ST_PAY: begin
                    if (bitCnt_q == 4'd7) begin
                        data_d      = window[7:0];
                        dataValid_d = 1'b1;
                        sof_d       = (byteCnt_q == 8'd0);
                        eof_d       = (byteCnt_q == len_q - 8'd1);
                        crc_d       = crc16Byte(crc_q, window[7:0]);
                        byteCnt_d   = byteCnt_q + 8'd1;
                        bitCnt_d    = 4'd0;
                        if (byteCnt_q == len_q - 8'd1) state_d = ST_CRC;
                    end
                end
                ST_CRC: begin
                    if (bitCnt_q == 4'd15) begin
                        crcDone_d = 1'b1;
                        crcOk_d   = (window == crc_q);
                        sof_d     = (len_q == 8'd0);
                        toHunt    = 1'b1;
                    end
                end
                default: ;
            endcase
        end

        if (toHunt) begin
            state_d   = ST_HUNT;
            hist_d    = '0;
            bitCnt_d  = 4'd0;
            byteCnt_d = 8'd0;
            gapCnt_d  = '0;
        end
    end

    // State and output registers; reset returns to an empty hunt.
    always_ff @(posedge i_clk20m) begin
        if (i_rst) begin
            state_q     <= ST_HUNT;
            hist_q      <= '0;
            bitCnt_q    <= 4'd0;
            byteCnt_q   <= 8'd0;
            gapCnt_q    <= '0;
            crc_q       <= 16'hFFFF;
            ident_q     <= 8'd0;
            len_q       <= 8'd0;
            data_q      <= 8'd0;
            dataValid_q <= 1'b0;
            sof_q       <= 1'b0;
            eof_q       <= 1'b0;
            crcDone_q   <= 1'b0;
            crcOk_q     <= 1'b0;
            abort_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            bitCnt_q    <= bitCnt_d;
            byteCnt_q   <= byteCnt_d;
            gapCnt_q    <= gapCnt_d;
            crc_q       <= crc_d;
            ident_q     <= ident_d;
            len_q       <= len_d;
            data_q      <= data_d;
            dataValid_q <= dataValid_d;
            sof_q       <= sof_d;
            eof_q       <= eof_d;
            crcDone_q   <= crcDone_d;
            crcOk_q     <= crcOk_d;
            abort_q     <= abort_d;
        end
    end

    assign o_ident      = ident_q;
    assign o_len        = len_q;
    assign o_data       = data_q;
    assign o_data_valid = dataValid_q;
    assign o_sof        = sof_q;
    assign o_eof        = eof_q;
    assign o_crc_done   = crcDone_q;
    assign o_crc_ok     = crcOk_q;
    assign o_abort      = abort_q;

endmodule

// File: tb/tb_rx_deframe_1to8.sv
// tb_rx_deframe_1to8
// Self-checking bench for rx_deframe_1to8. Frames are built at byte level,
// serialised MSB first with optional noise and idle gaps, and the expected
// output events (cycle, pulses, data, CRC verdict, held header) are derived
// from the frame contents and the cycle each bit was driven.
module tb_rx_deframe_1to8;

    localparam logic [15:0] SYNC   = 16'hEB90;
    localparam int          MAXLEN = 240;
    localparam int          GAPMAX = 16;

    typedef logic [7:0] byteQ_t[$];

    // pulses = {data_valid, sof, eof, crc_done, abort}
    typedef struct packed {
        logic       allZero;
        logic [4:0] pulses;
        logic [7:0] data;
        logic       ok;
        logic [7:0] ident;
        logic [7:0] len;
    } ev_t;

    logic       clock = 1'b0;
    logic       rstIn;
    logic       bitIn;
    logic       validIn;
    logic [7:0] oIdent, oLen, oData;
    logic       oDataValid, oSof, oEof, oCrcDone, oCrcOk, oAbort;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    ev_t  expEv[int];
    logic [7:0] curIdent = 8'd0;
    logic [7:0] curLen = 8'd0;

    rx_deframe_1to8 dut (
        .i_clk20m     (clock),
        .i_rst        (rstIn),
        .i_bit        (bitIn),
        .i_bit_valid  (validIn),
        .o_ident      (oIdent),
        .o_len        (oLen),
        .o_data       (oData),
        .o_data_valid (oDataValid),
        .o_sof        (oSof),
        .o_eof        (oEof),
        .o_crc_done   (oCrcDone),
        .o_crc_ok     (oCrcOk),
        .o_abort      (oAbort)
    );

    // 20 MHz clock and a cycle counter used to time-stamp expectations.
    always #25 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    // Compare outputs every cycle on the falling edge against the expected event map.
    always @(negedge clock) begin
        ev_t        e;
        logic [4:0] got;
        got = {oDataValid, oSof, oEof, oCrcDone, oAbort};
        if (expEv.exists(cyc)) begin
            e = expEv[cyc];
            expEv.delete(cyc);
            if (e.allZero) begin
                checkOutput("resetOutputs", {2'b00, oIdent, oLen, oData, got, oCrcOk}, 32'd0);
            end else begin
                checkOutput("pulses", {27'd0, got}, {27'd0, e.pulses});
                if (e.pulses[4]) checkOutput("data", {24'd0, oData}, {24'd0, e.data});
                if (e.pulses[1]) checkOutput("crcOk", {31'd0, oCrcOk}, {31'd0, e.ok});
                checkOutput("ident", {24'd0, oIdent}, {24'd0, e.ident});
                checkOutput("len", {24'd0, oLen}, {24'd0, e.len});
            end
        end else if (got != 5'd0) begin
            checkOutput("spurious", {27'd0, got}, 32'd0);
        end
    end

    function automatic logic [15:0] crcOf(input byteQ_t p);
        logic [15:0] r;
        logic        fb;
        r = 16'hFFFF;
        foreach (p[k]) begin
            for (int j = 7; j >= 0; j--) begin
                fb = r[15] ^ p[k][j];
                r  = {r[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        return r;
    endfunction

    function automatic bit accepts(input logic [15:0] w);
`ifdef SYNC_TOL1_EN
        return $countones(w ^ SYNC) <= 1;
`else
        return w == SYNC;
`endif
    endfunction

    function automatic int firstAccept(input logic bits[$]);
        logic [15:0] w;
        w = 16'd0;
        foreach (bits[i]) begin
            w = {w[14:0], bits[i]};
            if (accepts(w)) return i;
        end
        return -1;
    endfunction

    function automatic void pushEv(input int c, input logic [4:0] p, input logic [7:0] d, input logic ok);
        ev_t e;
        e.allZero = 1'b0;
        e.pulses  = p;
        e.data    = d;
        e.ok      = ok;
        e.ident   = curIdent;
        e.len     = curLen;
        expEv[c]  = e;
    endfunction

    task automatic driveCycle(input logic v, input logic b, output int sc);
        @(negedge clock);
        validIn = v;
        bitIn   = b;
        sc      = cyc + 1;
    endtask

    task automatic idle(input int n);
        int s;
        repeat (n) driveCycle(1'b0, 1'b0, s);
    endtask

    task automatic applyReset(input int n);
        int   s;
        int   keys[$];
        ev_t  e;
        @(negedge clock);
        rstIn   = 1'b1;
        validIn = 1'b0;
        bitIn   = 1'b0;
        s       = cyc + 1;
        foreach (expEv[k]) if (k >= s) keys.push_back(k);
        foreach (keys[i]) expEv.delete(keys[i]);
        e         = '0;
        e.allZero = 1'b1;
        expEv[s]  = e;
        curIdent  = 8'd0;
        curLen    = 8'd0;
        repeat (n - 1) @(negedge clock);
        rstIn = 1'b0;
    endtask

    // Sends noise then one frame; gapRel/stopRel are bit offsets from the first header bit.
    task automatic applyStimulus(input logic [15:0] sync, input logic [7:0] ident, input logic [7:0] len,
                                 input byteQ_t payload, input logic [15:0] rxCrc, input int noiseLen,
                                 input int gapRel, input int gapLen, input bit randGaps, input int stopRel);
        logic        bits[$];
        byteQ_t      fb;
        int          fa, hs, s, rel, k, nBits;
        bit          synced, stop;
        logic [15:0] goodCrc;
        goodCrc = crcOf(payload);
        hs      = noiseLen + 16;
        fb      = {ident, len};
        foreach (payload[i]) fb.push_back(payload[i]);
        fb.push_back(rxCrc[15:8]);
        fb.push_back(rxCrc[7:0]);
        fa = -1;
        for (int t = 0; t < 100; t++) begin
            bits = {};
            for (int i = 0; i < noiseLen; i++) bits.push_back(1'($urandom_range(0, 1)));
            for (int j = 15; j >= 0; j--) bits.push_back(sync[j]);
            foreach (fb[i]) for (int j = 7; j >= 0; j--) bits.push_back(fb[i][j]);
            fa = firstAccept(bits);
            if (fa == hs - 1 || (fa == -1 && !accepts(sync))) break;
        end
        synced = (fa == hs - 1);
        nBits  = bits.size();
        stop   = 1'b0;
        for (int i = 0; i < nBits && !stop; i++) begin
            rel = i - hs;
            if (rel >= 0 && rel == stopRel) break;
            if (synced && rel >= 0 && rel == gapRel) begin
                for (int g = 0; g < gapLen && g <= GAPMAX; g++) driveCycle(1'b0, 1'b0, s);
                if (gapLen > GAPMAX) begin
                    pushEv(s, 5'b00001, 8'd0, 1'b0);
                    break;
                end
            end else if (randGaps && $urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 3)) driveCycle(1'b0, 1'b0, s);
            end
            driveCycle(1'b1, bits[i], s);
            if (synced && rel >= 0) begin
                if (rel == 15) begin
                    curIdent = ident;
                    curLen   = len;
                    if (len > MAXLEN) begin
                        pushEv(s, 5'b00001, 8'd0, 1'b0);
                        stop = 1'b1;
                    end
                end else if (rel >= 16 && rel < 16 + 8 * len && (rel - 16) % 8 == 7) begin
                    k = (rel - 16) / 8;
                    pushEv(s, {1'b1, k == 0, k == len - 1, 2'b00}, payload[k], 1'b0);
                end else if (rel == 16 + 8 * len + 15) begin
                    pushEv(s, {1'b0, len == 0, 1'b0, 1'b1, 1'b0}, 8'd0, rxCrc == goodCrc);
                end
            end
        end
        driveCycle(1'b0, 1'b0, s);
    endtask

    initial begin
        byteQ_t      p1, emptyQ, rp;
        logic [7:0]  rLen;
        logic [15:0] rCrc;
        int          sel, gRel, gLen;
        rstIn   = 1'b1;
        validIn = 1'b0;
        bitIn   = 1'b0;
        for (int i = 0; i < 9; i++) p1.push_back(8'h31 + 8'(i));

        applyReset(3);
        idle(3);

        // Reference frame, good and corrupted CRC, then an empty payload.
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE7, 0, -1, 0, 1'b0, -1);
        idle(4);
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE6, 0, -1, 0, 1'b0, -1);
        idle(4);
        applyStimulus(SYNC, 8'hA5, 8'h00, emptyQ, 16'hFFFF, 0, -1, 0, 1'b0, -1);
        idle(4);

        // Noise before sync; gap of 16 tolerated, gap of 17 drops the frame.
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE7, 200, 16 + 35, 16, 1'b0, -1);
        idle(4);
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE7, 50, 16 + 35, 17, 1'b0, -1);
        idle(4);
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE7, 30, -1, 0, 1'b0, -1);
        idle(4);

        // Oversized LEN aborts right after the header, then recovery.
        applyStimulus(SYNC, 8'h77, 8'hF1, emptyQ, 16'h0000, 0, -1, 0, 1'b0, -1);
        idle(4);
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE7, 0, -1, 0, 1'b0, -1);
        idle(4);

        // One-bit-off sync word, then reset in the middle of the payload.
        applyStimulus(16'hEB91, 8'h5A, 8'h09, p1, 16'hAEE7, 0, -1, 0, 1'b0, -1);
        idle(4);
        applyReset(2);
        idle(2);
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE7, 0, -1, 0, 1'b0, 16 + 32);
        applyReset(2);
        idle(2);
        applyStimulus(SYNC, 8'h5A, 8'h09, p1, 16'hAEE7, 0, -1, 0, 1'b0, -1);
        idle(4);

        // Randomised frames: lengths incl. 0, MAX_LEN and oversized, bad CRCs, gaps.
        for (int f = 0; f < 24; f++) begin
            sel = $urandom_range(0, 9);
            if (sel == 0)      rLen = 8'd0;
            else if (sel == 1) rLen = 8'(MAXLEN);
            else if (sel == 2) rLen = 8'($urandom_range(MAXLEN + 1, 255));
            else               rLen = 8'($urandom_range(1, 32));
            rp = {};
            if (rLen <= MAXLEN) for (int i = 0; i < rLen; i++) rp.push_back(8'($urandom_range(0, 255)));
            rCrc = crcOf(rp);
            if ($urandom_range(0, 3) == 0) rCrc = rCrc ^ (16'd1 << $urandom_range(0, 15));
            gRel = -1;
            gLen = 0;
            if ($urandom_range(0, 2) == 0) begin
                gRel = (rLen > MAXLEN) ? $urandom_range(0, 15) : $urandom_range(0, 16 + 8 * rLen + 15);
                gLen = $urandom_range(4, 20);
            end
            applyStimulus(SYNC, 8'($urandom_range(0, 255)), rLen, rp, rCrc,
                          $urandom_range(0, 60), gRel, gLen, 1'b1, -1);
            idle($urandom_range(1, 6));
        end

        idle(8);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
